// File: rtl/i2s_sample_receiver_if.sv
// Signal bundle between an I2S ADC stream source and the sample receiver.
// The slave side is the receiver; dbg_state mirrors the receiver FSM for observation.
interface i2s_sample_receiver_if #(
  parameter int SAMPLE_WIDTH = 16
);
  logic                           bclk;
  logic                           lrclk;
  logic                           adcdat;
  logic signed [SAMPLE_WIDTH-1:0] leftSampleOut;
  logic signed [SAMPLE_WIDTH-1:0] rightSampleOut;
  logic                           sampleValid;
  logic                           frameError;
  logic [1:0]                     dbg_state;

  // sampleValid / frameError are single-cycle strobes with no ready;
  // a consumer that misses a strobe still sees the held sample outputs.
  modport master (
    output bclk, lrclk, adcdat,
    input  leftSampleOut, rightSampleOut, sampleValid, frameError, dbg_state
  );

  modport slave (
    input  bclk, lrclk, adcdat,
    output leftSampleOut, rightSampleOut, sampleValid, frameError, dbg_state
  );
endinterface

// File: rtl/i2s_sample_receiver.sv
// Oversampling I2S receiver: bclk/lrclk/adcdat are synchronised to clk and a
// left/right pair is presented once per complete frame with a sampleValid strobe.
module i2s_sample_receiver #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  i2s_sample_receiver_if.slave bus
);
  localparam int            CW   = $clog2(SAMPLE_WIDTH + 1);
  localparam logic [CW-1:0] FULL = CW'(SAMPLE_WIDTH);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, SHIFT = 2'd2, WAIT = 2'd3} state_t;

  state_t                         state_q, state_d;
  logic [SYNC_STAGES-1:0]         bclk_sync_q, lrclk_sync_q, adcdat_sync_q;
  logic                           bclk_prev_q;
  logic                           lr_prev_q, lr_prev_d;
  logic                           chan_q, chan_d;
  logic [CW-1:0]                  cnt_q, cnt_d, cnt_inc;
  logic [SAMPLE_WIDTH-1:0]        shift_q, shift_d, shifted;
  logic [SAMPLE_WIDTH-1:0]        left_hold_q, left_hold_d;
  logic                           left_ready_q, left_ready_d;
  logic signed [SAMPLE_WIDTH-1:0] left_out_q, left_out_d, right_out_q, right_out_d;
  logic                           valid_q, valid_d, err_q, err_d;
  logic                           bclk_s, lr_s, dat_s, rise, lr_change, word_done;

  assign bclk_s    = bclk_sync_q[SYNC_STAGES-1];
  assign lr_s      = lrclk_sync_q[SYNC_STAGES-1];
  assign dat_s     = adcdat_sync_q[SYNC_STAGES-1];
  assign rise      = bclk_s & ~bclk_prev_q;
  assign lr_change = lr_s ^ lr_prev_q;
  assign shifted   = {shift_q[SAMPLE_WIDTH-2:0], dat_s};
  assign cnt_inc   = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync_q   <= '0;
      lrclk_sync_q  <= '0;
      adcdat_sync_q <= '0;
      bclk_prev_q   <= 1'b0;
    end else begin
      bclk_sync_q   <= {bclk_sync_q[SYNC_STAGES-2:0], bus.bclk};
      lrclk_sync_q  <= {lrclk_sync_q[SYNC_STAGES-2:0], bus.lrclk};
      adcdat_sync_q <= {adcdat_sync_q[SYNC_STAGES-2:0], bus.adcdat};
      bclk_prev_q   <= bclk_s;
    end
  end

  // The rise that carries an lrclk change is the one-bit delay slot of the new
  // word; it may also carry the LSB of the previous word when slots are exactly
  // SAMPLE_WIDTH long, so the bit is shifted first and the count checked after.
  always_comb begin
    state_d      = state_q;
    lr_prev_d    = lr_prev_q;
    chan_d       = chan_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    left_hold_d  = left_hold_q;
    left_ready_d = left_ready_q;
    left_out_d   = left_out_q;
    right_out_d  = right_out_q;
    valid_d      = 1'b0;
    err_d        = 1'b0;
    word_done    = 1'b0;
    if (rise) begin
      lr_prev_d = lr_s;
      unique case (state_q)
        DELAY, SHIFT: begin
          shift_d = shifted;
          cnt_d   = cnt_inc;
          state_d = SHIFT;
          if (cnt_inc == FULL) begin
            word_done = 1'b1;
            state_d   = WAIT;
          end else if (lr_change) begin
            err_d        = 1'b1;
            left_ready_d = 1'b0;
          end
        end
        IDLE, WAIT: ;
        default: state_d = IDLE;
      endcase
      if (word_done) begin
        if (!chan_q) begin
          left_hold_d  = shifted;
          left_ready_d = 1'b1;
        end else if (left_ready_q) begin
          left_out_d   = $signed(left_hold_q);
          right_out_d  = $signed(shifted);
          valid_d      = 1'b1;
          left_ready_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      if (lr_change) begin
        state_d = DELAY;
        chan_d  = lr_s;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      lr_prev_q    <= 1'b0;
      chan_q       <= 1'b0;
      cnt_q        <= '0;
      shift_q      <= '0;
      left_hold_q  <= '0;
      left_ready_q <= 1'b0;
      left_out_q   <= '0;
      right_out_q  <= '0;
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lr_prev_q    <= lr_prev_d;
      chan_q       <= chan_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      left_hold_q  <= left_hold_d;
      left_ready_q <= left_ready_d;
      left_out_q   <= left_out_d;
      right_out_q  <= right_out_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
    end
  end

  assign bus.leftSampleOut  = left_out_q;
  assign bus.rightSampleOut = right_out_q;
  assign bus.sampleValid    = valid_q;
  assign bus.frameError     = err_q;
  assign bus.dbg_state      = state_q;
endmodule
